huffman_encoder: RTL and testbench

HUFFMAN_ENCODER -- requirements
Module: huffman_encoder

---
 rtl/huffman_encoder.sv | 22 ++
 tb/tb_huffman_encoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/huffman_encoder.sv
// huffman_encoder: fixed three-class prefix code, one registered codeword per accepted symbol.
module huffman_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_enable,
  input  logic [7:0]  data_in,
  output logic [15:0] data_out
);
  logic [15:0] data_q, data_d, code;
  // Only the low five bits of (sym-8) are kept, so a 5-bit subtract is exact.
  always_comb begin
    code = data_in < 8'd8  ? {4'd4, 8'd0, 1'b0, data_in[2:0]} :
           data_in < 8'd40 ? {4'd7, 5'd0, 2'b10, data_in[4:0] - 5'd8} :
                             {4'd10, 2'd0, 2'b11, data_in - 8'd40};
    data_d = !enable ? data_q : in_enable ? code : 16'h0000;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) data_q <= 16'h0000;
    else      data_q <= data_d;
  assign data_out = data_q;
endmodule

// File: tb/tb_huffman_encoder.sv
// tb_huffman_encoder: randomized and directed checks against an arithmetic code-table model.
module tb_huffman_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        in_enable = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] data_out;
  int pass_cnt = 0;
  int total = 0;

  huffman_encoder dut (
    .clk(clk), .rst(rst), .enable(enable), .in_enable(in_enable),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_code(input int sym);
    int len, cw;
    if (sym < 8)       begin len = 4;  cw = sym; end
    else if (sym < 40) begin len = 7;  cw = 64 + (sym - 8); end
    else               begin len = 10; cw = 768 + (sym - 40); end
    return 16'(len * 4096 + cw);
  endfunction

  task automatic step(input logic en, input logic ien, input logic [7:0] d);
    @(negedge clk);
    enable = en; in_enable = ien; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    total++;
    if (data_out !== 16'h0000) $display("FAIL reset_value got %h exp 0000", data_out);
    else pass_cnt++;
    repeat (2) step(1'b1, 1'b1, 8'd100);
    total++;
    if (data_out !== 16'h0000) $display("FAIL reset_hold got %h exp 0000", data_out);
    else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'hxx);
      total++;
      if (data_out !== 16'h0000) $display("FAIL idle_%0d got %h exp 0000", i, data_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_stream;
    logic [7:0]  syms [8] = '{8'd5, 8'd68, 8'd50, 8'd100, 8'd150, 8'd200, 8'd250, 8'd255};
    logic [15:0] exps [8] = '{16'h4005, 16'hA31C, 16'hA30A, 16'hA33C, 16'hA36E, 16'hA3A0, 16'hA3D2, 16'hA3D7};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, syms[i]);
      total++;
      if (data_out !== exps[i]) $display("FAIL stream_%0d sym %0d got %h exp %h", i, syms[i], data_out, exps[i]);
      else pass_cnt++;
      total++;
      if (data_out !== ref_code(int'(syms[i]))) $display("FAIL model_%0d got %h exp %h", i, data_out, ref_code(int'(syms[i])));
      else pass_cnt++;
    end
  endtask

  task automatic test_boundaries;
    logic [7:0]  syms [6] = '{8'd0, 8'd7, 8'd8, 8'd39, 8'd40, 8'd255};
    logic [15:0] exps [6] = '{16'h4000, 16'h4007, 16'h7040, 16'h705F, 16'hA300, 16'hA3D7};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, syms[i]);
      total++;
      if (data_out !== exps[i]) $display("FAIL boundary_%0d sym %0d got %h exp %h", i, syms[i], data_out, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_valid_drop;
    step(1'b1, 1'b1, 8'd100);
    step(1'b1, 1'b0, 8'd100);
    total++;
    if (data_out !== 16'h0000) $display("FAIL valid_drop got %h exp 0000", data_out);
    else pass_cnt++;
  endtask

  task automatic test_hold;
    step(1'b1, 1'b1, 8'd255);
    step(1'b0, 1'b1, 8'd3);
    step(1'b0, 1'b0, 8'hxx);
    step(1'b0, 1'b1, 8'd255);
    total++;
    if (data_out !== 16'hA3D7) $display("FAIL hold got %h exp a3d7", data_out);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [15:0] exp_q = data_out;
    for (int i = 0; i < 300; i++) begin
      logic en, ien;
      logic [7:0] d;
      en  = ($urandom_range(0, 3) != 0);
      ien = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      if (en) exp_q = ien ? ref_code(int'(d)) : 16'h0000;
      step(en, ien, (en && ien) ? d : 8'hxx);
      total++;
      if (data_out !== exp_q) $display("FAIL random_%0d en %b ien %b d %0d got %h exp %h", i, en, ien, d, data_out, exp_q);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 1'b1, 8'd150);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (data_out !== 16'h0000) $display("FAIL async_reset got %h exp 0000", data_out);
    else pass_cnt++;
    step(1'b1, 1'b1, 8'd200);
    total++;
    if (data_out !== 16'h0000) $display("FAIL async_hold got %h exp 0000", data_out);
    else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    step(1'b1, 1'b1, 8'd8);
    total++;
    if (data_out !== 16'h7040) $display("FAIL post_reset got %h exp 7040", data_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_boundaries;
    test_valid_drop;
    test_hold;
    test_random;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
